// File: rtl/snake_engine.sv
`default_nettype none
// ============================================================================
//  Module      : snake_engine
//  Description : Grid-based snake game core. Body kept in a circular buffer
//                plus an occupancy bitmap; one step per update tick. Wall or
//                wrap-around boundaries, self-collision with tail-vacate
//                exception, apple respawn with raster retry, win condition.
//                Answers per-pixel classification queries with 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_engine #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int CELL_LOG2 = 3,
    parameter int MAX_LEN   = 128,
    parameter int WRAP      = 0,
    parameter int START_X   = 40,
    parameter int START_Y   = 30,
    parameter int APPLE0_X  = 20,
    parameter int APPLE0_Y  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        tick,
    input  logic [4:0]                  direction,
    input  logic [9:0]                  rand_x,
    input  logic [8:0]                  rand_y,
    input  logic [9:0]                  x_pos,
    input  logic [9:0]                  y_pos,
    output logic                        pix_head,
    output logic                        pix_body,
    output logic                        pix_apple,
    output logic                        pix_border,
    output logic [$clog2(MAX_LEN):0]    length,
    output logic [15:0]                 score,
    output logic                        game_over,
    output logic                        game_won,
    output logic                        busy
);

    localparam int c_XW    = $clog2(GRID_W);
    localparam int c_YW    = $clog2(GRID_H);
    localparam int c_PW    = $clog2(MAX_LEN);
    localparam int c_LW    = c_PW + 1;
    localparam int c_CELLS = GRID_W * GRID_H;
    localparam int c_IW    = $clog2(c_CELLS);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_INIT  = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_MOVE  = 3'd3;
    localparam logic [2:0] c_PLACE = 3'd4;
    localparam logic [2:0] c_OVER  = 3'd5;
    localparam logic [2:0] c_WON   = 3'd6;

    localparam logic [4:0] c_DIR_UP    = 5'b00010;
    localparam logic [4:0] c_DIR_LEFT  = 5'b00100;
    localparam logic [4:0] c_DIR_DOWN  = 5'b01000;
    localparam logic [4:0] c_DIR_RIGHT = 5'b10000;

    localparam logic [c_XW-1:0] c_X_MAX = c_XW'(GRID_W - 1);
    localparam logic [c_YW-1:0] c_Y_MAX = c_YW'(GRID_H - 1);

    // Linear bitmap index of a grid cell (row-major)
    function automatic logic [c_IW-1:0] cell_idx(input logic [c_XW-1:0] x,
                                                 input logic [c_YW-1:0] y);
        return c_IW'(y) * c_IW'(GRID_W) + c_IW'(x);
    endfunction

    // The direction code that would make the snake turn back on itself
    function automatic logic [4:0] opposite(input logic [4:0] d);
        case (d)
            c_DIR_UP:    return c_DIR_DOWN;
            c_DIR_DOWN:  return c_DIR_UP;
            c_DIR_LEFT:  return c_DIR_RIGHT;
            c_DIR_RIGHT: return c_DIR_LEFT;
            default:     return 5'b00000;
        endcase
    endfunction

    logic [2:0]       r_state, w_state_next;
    logic [c_CELLS-1:0] r_bitmap;
    logic [c_XW-1:0]  r_ring_x [MAX_LEN];
    logic [c_YW-1:0]  r_ring_y [MAX_LEN];
    logic [c_PW-1:0]  r_head_ptr, r_tail_ptr;
    logic [c_XW-1:0]  r_head_x, r_apple_x, r_nx, r_cand_x;
    logic [c_YW-1:0]  r_head_y, r_apple_y, r_ny, r_cand_y;
    logic             r_oob, r_place_first;
    logic [c_LW-1:0]  r_length;
    logic [15:0]      r_score;
    logic             r_game_over, r_game_won;
    logic [4:0]       r_cur_dir, r_pend_dir;
    logic             r_pix_head, r_pix_body, r_pix_apple, r_pix_border;

    logic [c_XW-1:0]  w_nx, w_tail_x, w_cand_x, w_cand_nx;
    logic [c_YW-1:0]  w_ny, w_tail_y, w_cand_y, w_cand_ny;
    logic             w_oob, w_eat, w_hit_tail, w_occ, w_die, w_full, w_cand_free;
    logic             w_dir_ok;
    logic [c_LW-1:0]  w_len_inc;
    logic [c_PW-1:0]  w_push_ptr;

    assign w_tail_x   = r_ring_x[r_tail_ptr];
    assign w_tail_y   = r_ring_y[r_tail_ptr];
    assign w_push_ptr = r_head_ptr + c_PW'(1);
    assign w_len_inc  = r_length + c_LW'(1);
    assign w_full     = (w_len_inc == c_LW'(MAX_LEN));
    assign w_dir_ok   = (direction == c_DIR_UP) || (direction == c_DIR_DOWN) ||
                        (direction == c_DIR_LEFT) || (direction == c_DIR_RIGHT);

    // Next head cell from the pending direction, with wrap or wall detection
    always_comb begin
        w_nx  = r_head_x;
        w_ny  = r_head_y;
        w_oob = 1'b0;
        case (r_pend_dir)
            c_DIR_UP: begin
                if (r_head_y == '0) begin
                    w_ny  = c_Y_MAX;
                    w_oob = (WRAP == 0);
                end else begin
                    w_ny = r_head_y - c_YW'(1);
                end
            end
            c_DIR_DOWN: begin
                if (r_head_y == c_Y_MAX) begin
                    w_ny  = '0;
                    w_oob = (WRAP == 0);
                end else begin
                    w_ny = r_head_y + c_YW'(1);
                end
            end
            c_DIR_LEFT: begin
                if (r_head_x == '0) begin
                    w_nx  = c_X_MAX;
                    w_oob = (WRAP == 0);
                end else begin
                    w_nx = r_head_x - c_XW'(1);
                end
            end
            c_DIR_RIGHT: begin
                if (r_head_x == c_X_MAX) begin
                    w_nx  = '0;
                    w_oob = (WRAP == 0);
                end else begin
                    w_nx = r_head_x + c_XW'(1);
                end
            end
            default: ;
        endcase
    end

    // Move outcome: stepping into the tail cell is legal only when the tail leaves
    assign w_eat      = (r_nx == r_apple_x) && (r_ny == r_apple_y);
    assign w_hit_tail = (r_nx == w_tail_x) && (r_ny == w_tail_y);
    assign w_occ      = r_bitmap[cell_idx(r_nx, r_ny)];
    assign w_die      = r_oob || (w_occ && !(w_hit_tail && !w_eat));

    // Apple candidate: random seed on the first PLACE cycle, then raster retry
    assign w_cand_x    = r_place_first ? c_XW'(rand_x % 10'(GRID_W)) : r_cand_x;
    assign w_cand_y    = r_place_first ? c_YW'(rand_y % 9'(GRID_H))  : r_cand_y;
    assign w_cand_free = !r_bitmap[cell_idx(w_cand_x, w_cand_y)];

    // Raster-order successor of the current candidate, wrapping to (0,0)
    always_comb begin
        w_cand_nx = w_cand_x + c_XW'(1);
        w_cand_ny = w_cand_y;
        if (w_cand_x == c_X_MAX) begin
            w_cand_nx = '0;
            w_cand_ny = (w_cand_y == c_Y_MAX) ? '0 : w_cand_y + c_YW'(1);
        end
    end

    // Next-state logic; dropping start aborts to IDLE from anywhere
    always_comb begin
        w_state_next = r_state;
        if (!start) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  w_state_next = c_INIT;
                c_INIT:  w_state_next = c_RUN;
                c_RUN:   if (tick) w_state_next = c_MOVE;
                c_MOVE: begin
                    if (w_die)       w_state_next = c_OVER;
                    else if (!w_eat) w_state_next = c_RUN;
                    else if (w_full) w_state_next = c_WON;
                    else             w_state_next = c_PLACE;
                end
                c_PLACE: if (w_cand_free) w_state_next = c_RUN;
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    // Game datapath: ring buffer, bitmap, counters, flags, apple placement
    always_ff @(posedge clk) begin
        if (rst || !start) begin
            r_bitmap      <= '0;
            r_head_ptr    <= '0;
            r_tail_ptr    <= '0;
            r_length      <= '0;
            r_score       <= '0;
            r_game_over   <= 1'b0;
            r_game_won    <= 1'b0;
            r_cur_dir     <= c_DIR_RIGHT;
            r_pend_dir    <= c_DIR_RIGHT;
            r_head_x      <= '0;
            r_head_y      <= '0;
            r_apple_x     <= '0;
            r_apple_y     <= '0;
            r_nx          <= '0;
            r_ny          <= '0;
            r_oob         <= 1'b0;
            r_cand_x      <= '0;
            r_cand_y      <= '0;
            r_place_first <= 1'b0;
        end else begin
            case (r_state)
                c_INIT: begin
                    r_ring_x[r_head_ptr] <= c_XW'(START_X);
                    r_ring_y[r_head_ptr] <= c_YW'(START_Y);
                    r_bitmap[cell_idx(c_XW'(START_X), c_YW'(START_Y))] <= 1'b1;
                    r_head_x  <= c_XW'(START_X);
                    r_head_y  <= c_YW'(START_Y);
                    r_length  <= c_LW'(1);
                    r_score   <= '0;
                    r_apple_x <= c_XW'(APPLE0_X);
                    r_apple_y <= c_YW'(APPLE0_Y);
                    r_cur_dir <= c_DIR_RIGHT;
                end
                c_RUN: begin
                    if (w_dir_ok && (direction != opposite(r_cur_dir)))
                        r_pend_dir <= direction;
                    if (tick) begin
                        r_cur_dir <= r_pend_dir;
                        r_nx      <= w_nx;
                        r_ny      <= w_ny;
                        r_oob     <= w_oob;
                    end
                end
                c_MOVE: begin
                    if (w_die) begin
                        r_game_over <= 1'b1;
                    end else begin
                        // Tail clear precedes head set so a tail-chase keeps the bit
                        if (!w_eat) begin
                            r_bitmap[cell_idx(w_tail_x, w_tail_y)] <= 1'b0;
                            r_tail_ptr <= r_tail_ptr + c_PW'(1);
                        end
                        r_ring_x[w_push_ptr] <= r_nx;
                        r_ring_y[w_push_ptr] <= r_ny;
                        r_head_ptr <= w_push_ptr;
                        r_bitmap[cell_idx(r_nx, r_ny)] <= 1'b1;
                        r_head_x <= r_nx;
                        r_head_y <= r_ny;
                        if (w_eat) begin
                            r_length <= w_len_inc;
                            if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                            if (w_full) r_game_won    <= 1'b1;
                            else        r_place_first <= 1'b1;
                        end
                    end
                end
                c_PLACE: begin
                    r_place_first <= 1'b0;
                    if (w_cand_free) begin
                        r_apple_x <= w_cand_x;
                        r_apple_y <= w_cand_y;
                    end else begin
                        r_cand_x <= w_cand_nx;
                        r_cand_y <= w_cand_ny;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [9:0]      w_px, w_py;
    logic [c_XW-1:0] w_qx;
    logic [c_YW-1:0] w_qy;
    logic [c_IW-1:0] w_qidx;
    logic            w_inside, w_q_head, w_apple_vis;

    assign w_px        = x_pos >> CELL_LOG2;
    assign w_py        = y_pos >> CELL_LOG2;
    assign w_qx        = w_px[c_XW-1:0];
    assign w_qy        = w_py[c_YW-1:0];
    assign w_inside    = (w_px < 10'(GRID_W)) && (w_py < 10'(GRID_H));
    assign w_qidx      = w_inside ? cell_idx(w_qx, w_qy) : '0;
    assign w_q_head    = w_inside && (r_length != '0) &&
                         (w_qx == r_head_x) && (w_qy == r_head_y);
    assign w_apple_vis = (r_state == c_RUN) || (r_state == c_MOVE) || (r_state == c_PLACE);

    // Registered pixel classification, blanked in IDLE
    always_ff @(posedge clk) begin
        if (rst || (r_state == c_IDLE)) begin
            r_pix_head   <= 1'b0;
            r_pix_body   <= 1'b0;
            r_pix_apple  <= 1'b0;
            r_pix_border <= 1'b0;
        end else begin
            r_pix_head   <= w_q_head;
            r_pix_body   <= w_inside && r_bitmap[w_qidx] && !w_q_head;
            r_pix_apple  <= w_inside && w_apple_vis &&
                            (w_qx == r_apple_x) && (w_qy == r_apple_y);
            r_pix_border <= (WRAP == 0) && w_inside &&
                            ((w_qx == '0) || (w_qx == c_X_MAX) ||
                             (w_qy == '0) || (w_qy == c_Y_MAX));
        end
    end

    assign pix_head   = r_pix_head;
    assign pix_body   = r_pix_body;
    assign pix_apple  = r_pix_apple;
    assign pix_border = r_pix_border;
    assign length     = r_length;
    assign score      = r_score;
    assign game_over  = r_game_over;
    assign game_won   = r_game_won;
    assign busy       = (r_state == c_INIT) || (r_state == c_MOVE) || (r_state == c_PLACE);

endmodule
`default_nettype wire
